instr_mem_loader: RTL and testbench

- Writer side of the instruction memory: accepts a byte stream from a host link (UART/debug bridge), assembles little-endian 32-bit instruction words and issues word writes into a writable instruction RAM.
- The single-cycle core fetches from that RAM through its combinational read port.
- Holds the core in reset while a program is being loaded and releases it when loading completes.

---
 rtl/instr_mem_pkg.sv | 20 ++
 rtl/instr_ram.sv | 46 ++++
 rtl/instr_mem_loader.sv | 132 +++++++++++++
 tb/tb_instr_mem_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction RAM.
// Holds:
//   ADDR_W, DEPTH_WORDS  byte-address width and word depth of the instruction RAM
//   NOP_INSTR            RV32I "addi x0,x0,0", used to fill the RAM on init
//   loader_state_t       loader FSM state encoding
package instr_mem_pkg;

    localparam int ADDR_W      = 8;
    localparam int DEPTH_WORDS = 64;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/instr_ram.sv
// Writable instruction RAM, DEPTH_WORDS x 32 bits.
// Sits beside instr_mem_loader: the loader drives the write port, the core
// fetches through the combinational read port.
// Ports:
//   clk    system clock
//   init   synchronous fill of every word with NOP_INSTR (takes priority over we)
//   we     word write enable
//   waddr  byte address of the write, word index waddr[ADDR_W-1:2]
//   wdata  word to write
//   a      core fetch byte address, word index a[ADDR_W-1:2]
//   rd     fetched word (combinational)
module instr_ram
    import instr_mem_pkg::*;
#(
    parameter int RAM_ADDR_W      = ADDR_W,
    parameter int RAM_DEPTH_WORDS = DEPTH_WORDS
) (
    input  logic                  clk,
    input  logic                  init,
    input  logic                  we,
    input  logic [RAM_ADDR_W-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [RAM_ADDR_W-1:0] a,
    output logic [31:0]           rd
);

    logic [31:0] mem [RAM_DEPTH_WORDS];

    // Word-aligned storage: the two byte-offset bits never select anything.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{waddr[1:0], a[1:0]};

    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < RAM_DEPTH_WORDS; i++) begin
                mem[i] <= NOP_INSTR;
            end
        end else if (we) begin
            mem[waddr[RAM_ADDR_W-1:2]] <= wdata;
        end
    end

    // Single-cycle core fetches in the same cycle it presents the address.
    assign rd = mem[a[RAM_ADDR_W-1:2]];

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program into the instruction RAM from a host byte stream.
// Bytes arrive little-endian; every four accepted bytes form one 32-bit word
// which is written to the RAM in a dedicated single write cycle. The core is
// held in reset from power-up (and during any load) until a session completes.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      request a session; num_words sampled with it (legal 1..DEPTH_WORDS)
//   in_valid, in_data, in_ready   byte-stream handshake
//   we, waddr, wdata              RAM write port
//   cpu_hold   core reset hold
//   busy       high during RECV and WRITE
//   done       one-cycle pulse closing a session
//   err        sticky: last start had an illegal num_words
module instr_mem_loader
    import instr_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [6:0]        num_words,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [6:0] MAX_WORDS = 7'(DEPTH_WORDS);

    loader_state_t state_reg, state_next;
    logic [1:0]    byte_idx_reg, byte_idx_next;
    logic [6:0]    word_cnt_reg, word_cnt_next;
    logic [6:0]    num_words_reg, num_words_next;
    logic [31:0]   wdata_reg, wdata_next;
    logic          err_reg, err_next;
    logic          cpu_hold_reg, cpu_hold_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            byte_idx_reg  <= 2'd0;
            word_cnt_reg  <= 7'd0;
            num_words_reg <= 7'd0;
            wdata_reg     <= 32'd0;
            err_reg       <= 1'b0;
            cpu_hold_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            byte_idx_reg  <= byte_idx_next;
            word_cnt_reg  <= word_cnt_next;
            num_words_reg <= num_words_next;
            wdata_reg     <= wdata_next;
            err_reg       <= err_next;
            cpu_hold_reg  <= cpu_hold_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        byte_idx_next  = byte_idx_reg;
        word_cnt_next  = word_cnt_reg;
        num_words_next = num_words_reg;
        wdata_next     = wdata_reg;
        err_next       = err_reg;
        cpu_hold_next  = cpu_hold_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if ((num_words != 7'd0) && (num_words <= MAX_WORDS)) begin
                        num_words_next = num_words;
                        word_cnt_next  = 7'd0;
                        byte_idx_next  = 2'd0;
                        err_next       = 1'b0;
                        cpu_hold_next  = 1'b1;
                        state_next     = ST_RECV;
                    end else begin
                        // Rejected request leaves cpu_hold alone so a running
                        // program is not disturbed by a bad host command.
                        err_next = 1'b1;
                    end
                end
            end

            ST_RECV: begin
                // in_ready is high for the whole state, so in_valid alone
                // decides whether the handshake fires.
                if (in_valid) begin
                    wdata_next[8*byte_idx_reg +: 8] = in_data;
                    byte_idx_next = byte_idx_reg + 2'd1;  // wraps 3 -> 0
                    if (byte_idx_reg == 2'd3) begin
                        state_next = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                word_cnt_next = word_cnt_reg + 7'd1;
                if (word_cnt_next == num_words_reg) begin
                    // Registered so the hold falls in the same cycle as done.
                    cpu_hold_next = 1'b0;
                    state_next    = ST_DONE;
                end else begin
                    state_next = ST_RECV;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign in_ready = (state_reg == ST_RECV);
    assign we       = (state_reg == ST_WRITE);
    assign busy     = (state_reg == ST_RECV) || (state_reg == ST_WRITE);
    assign done     = (state_reg == ST_DONE);
    assign waddr    = {word_cnt_reg[ADDR_W-3:0], 2'b00};
    assign wdata    = wdata_reg;
    assign err      = err_reg;
    assign cpu_hold = cpu_hold_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with an instr_ram attached to its write
// port, so loaded words can be read back through the fetch port.
module tb_instr_mem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  num_words;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    logic        ram_init;
    logic [7:0]  ram_a;
    logic [31:0] ram_rd;

    int n_cmp = 0;
    int n_err = 0;

    // Per-session observations gathered by run_load.
    logic [7:0]  stream[$];
    logic [7:0]  log_addr[$];
    logic [31:0] log_data[$];
    int          done_cyc;
    int          done_cnt;
    int          order_viol;
    int          ready_in_write;

    instr_mem_loader u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_words (num_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    instr_ram u_ram (
        .clk   (clk),
        .init  (ram_init),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .a     (ram_a),
        .rd    (ram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Enters at a negedge. With do_start the start pulse is issued first;
    // either way cycle 1 is the first RECV cycle. Returns at the negedge after
    // done (or after the reset when abort_fires > 0).
    task automatic run_load(input bit gapped, input bit do_start, input int nw,
                            input int poke_cyc, input int abort_fires);
        int idx;
        log_addr.delete();
        log_data.delete();
        done_cyc = 0;
        done_cnt = 0;
        order_viol = 0;
        ready_in_write = 0;
        idx = 0;
        if (do_start) begin
            @(negedge clk);
            start = 1'b1;
            num_words = 7'(nw);
            @(negedge clk);
            start = 1'b0;
        end
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (abort_fires > 0 && idx >= abort_fires) begin
                rst = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            if (we) begin
                if (idx != 4 * (log_addr.size() + 1)) order_viol++;
                if (in_ready) ready_in_write++;
                log_addr.push_back(waddr);
                log_data.push_back(wdata);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                in_valid = 1'b0;
                start = 1'b0;
                @(negedge clk);
                break;
            end
            if (cyc == poke_cyc) begin
                start = 1'b1;
                num_words = 7'd5;
            end else begin
                start = 1'b0;
            end
            if (idx < stream.size()) begin
                in_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data = stream[idx];
                if (in_valid && in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        num_words = 7'd0;
        in_valid = 1'b0;
        in_data = 8'd0;
        ram_init = 1'b1;
        ram_a = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ram_init = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL reset_cpu_hold got=%b want=1", cpu_hold); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL reset_we got=%b want=0", we); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b want=0", err); end
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done got=%b want=00", {busy, done}); end
        n_cmp++; if ({waddr, wdata} !== 40'd0) begin n_err++; $display("FAIL reset_waddr_wdata got=%h/%h want=00/00000000", waddr, wdata); end
        n_cmp++; if (ram_rd !== 32'h0000_0013) begin n_err++; $display("FAIL reset_ram_nop got=%h want=00000013", ram_rd); end
        $display("test_reset: cpu_hold=%b in_ready=%b we=%b err=%b", cpu_hold, in_ready, we, err);
    endtask

    task automatic load_two_word_stream();
        stream.delete();
        stream = '{8'h93, 8'h00, 8'hB0, 8'h0A, 8'h23, 8'h05, 8'h10, 8'h00};
    endtask

    task automatic test_load_streaming();
        load_two_word_stream();
        run_load(1'b0, 1'b1, 2, 0, 0);
        n_cmp++; if (log_addr.size() !== 2) begin n_err++; $display("FAIL stream_write_count got=%0d want=2", log_addr.size()); end
        if (log_addr.size() == 2) begin
            n_cmp++; if (log_addr[0] !== 8'h00 || log_data[0] !== 32'h0AB0_0093) begin n_err++; $display("FAIL stream_write0 got=%h/%h want=00/0ab00093", log_addr[0], log_data[0]); end
            n_cmp++; if (log_addr[1] !== 8'h04 || log_data[1] !== 32'h0010_0523) begin n_err++; $display("FAIL stream_write1 got=%h/%h want=04/00100523", log_addr[1], log_data[1]); end
        end
        n_cmp++; if (done_cyc !== 11) begin n_err++; $display("FAIL stream_done_cycle got=%0d want=11", done_cyc); end
        n_cmp++; if (done_cnt !== 1 || done !== 1'b0) begin n_err++; $display("FAIL stream_done_once got=%0d/%b want=1/0", done_cnt, done); end
        n_cmp++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL stream_cpu_hold got=%b want=0", cpu_hold); end
        ram_a = 8'h04;
        #1;
        n_cmp++; if (ram_rd !== 32'h0010_0523) begin n_err++; $display("FAIL stream_ram_a04 got=%h want=00100523", ram_rd); end
        ram_a = 8'h00;
        #1;
        n_cmp++; if (ram_rd !== 32'h0AB0_0093) begin n_err++; $display("FAIL stream_ram_a00 got=%h want=0ab00093", ram_rd); end
        $display("test_load_streaming: writes=%0d done_cyc=%0d cpu_hold=%b", log_addr.size(), done_cyc, cpu_hold);
    endtask

    task automatic test_load_gapped();
        @(negedge clk);
        ram_init = 1'b1;
        @(negedge clk);
        ram_init = 1'b0;
        load_two_word_stream();
        run_load(1'b1, 1'b1, 2, 0, 0);
        n_cmp++; if (log_addr.size() !== 2) begin n_err++; $display("FAIL gapped_write_count got=%0d want=2", log_addr.size()); end
        if (log_addr.size() == 2) begin
            n_cmp++; if (log_addr[0] !== 8'h00 || log_data[0] !== 32'h0AB0_0093) begin n_err++; $display("FAIL gapped_write0 got=%h/%h want=00/0ab00093", log_addr[0], log_data[0]); end
            n_cmp++; if (log_addr[1] !== 8'h04 || log_data[1] !== 32'h0010_0523) begin n_err++; $display("FAIL gapped_write1 got=%h/%h want=04/00100523", log_addr[1], log_data[1]); end
        end
        n_cmp++; if (order_viol !== 0) begin n_err++; $display("FAIL gapped_write_before_4th_byte got=%0d want=0", order_viol); end
        n_cmp++; if (ready_in_write !== 0) begin n_err++; $display("FAIL gapped_ready_in_write got=%0d want=0", ready_in_write); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL gapped_done got=%0d want=1", done_cnt); end
        ram_a = 8'h04;
        #1;
        n_cmp++; if (ram_rd !== 32'h0010_0523) begin n_err++; $display("FAIL gapped_ram_a04 got=%h want=00100523", ram_rd); end
        ram_a = 8'h08;
        #1;
        n_cmp++; if (ram_rd !== 32'h0000_0013) begin n_err++; $display("FAIL gapped_ram_a08_untouched got=%h want=00000013", ram_rd); end
        $display("test_load_gapped: writes=%0d done_cyc=%0d", log_addr.size(), done_cyc);
    endtask

    task automatic test_illegal_count();
        logic [6:0] bad[2];
        bad[0] = 7'd0;
        bad[1] = 7'd65;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b1;
            num_words = bad[k];
            @(negedge clk);
            start = 1'b0;
            n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL illegal_err n=%0d got=%b want=1", bad[k], err); end
            n_cmp++; if ({busy, in_ready, we} !== 3'b000) begin n_err++; $display("FAIL illegal_idle n=%0d got=%b want=000", bad[k], {busy, in_ready, we}); end
            n_cmp++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL illegal_cpu_hold n=%0d got=%b want=0", bad[k], cpu_hold); end
            $display("test_illegal_count: num_words=%0d err=%b busy=%b", bad[k], err, busy);
        end
        @(negedge clk);
        start = 1'b1;
        num_words = 7'd1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (err !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL legal_clears_err got=%b/%b want=0/1", err, busy); end
        stream.delete();
        stream = '{8'h13, 8'h01, 8'h10, 8'h00};
        run_load(1'b0, 1'b0, 1, 0, 0);
        n_cmp++; if (log_addr.size() !== 1) begin n_err++; $display("FAIL legal_one_write_count got=%0d want=1", log_addr.size()); end
        if (log_addr.size() == 1) begin
            n_cmp++; if (log_addr[0] !== 8'h00 || log_data[0] !== 32'h0010_0113) begin n_err++; $display("FAIL legal_one_write got=%h/%h want=00/00100113", log_addr[0], log_data[0]); end
        end
        n_cmp++; if (done_cyc !== 6) begin n_err++; $display("FAIL legal_one_done_cycle got=%0d want=6", done_cyc); end
        $display("test_illegal_count: legal start err=%b writes=%0d done_cyc=%0d", err, log_addr.size(), done_cyc);
    endtask

    task automatic test_reset_mid_session();
        stream.delete();
        stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                   8'h99, 8'hAA, 8'hBB, 8'hCC};
        run_load(1'b0, 1'b1, 3, 0, 6);
        n_cmp++; if (log_addr.size() !== 1) begin n_err++; $display("FAIL midrst_write_count got=%0d want=1", log_addr.size()); end
        if (log_addr.size() == 1) begin
            n_cmp++; if (log_data[0] !== 32'h4433_2211) begin n_err++; $display("FAIL midrst_write0 got=%h want=44332211", log_data[0]); end
        end
        n_cmp++; if ({busy, in_ready, we, done} !== 4'b0000) begin n_err++; $display("FAIL midrst_idle got=%b want=0000", {busy, in_ready, we, done}); end
        n_cmp++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL midrst_cpu_hold got=%b want=1", cpu_hold); end
        n_cmp++; if ({waddr, wdata} !== 40'd0) begin n_err++; $display("FAIL midrst_regs got=%h/%h want=00/00000000", waddr, wdata); end
        for (int c = 0; c < 6; c++) begin
            n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL midrst_late_we cycle=%0d got=%b want=0", c, we); end
            @(negedge clk);
        end
        ram_a = 8'h00;
        #1;
        n_cmp++; if (ram_rd !== 32'h4433_2211) begin n_err++; $display("FAIL midrst_ram_word0 got=%h want=44332211", ram_rd); end
        ram_a = 8'h04;
        #1;
        n_cmp++; if (ram_rd !== 32'h0010_0523) begin n_err++; $display("FAIL midrst_ram_word1 got=%h want=00100523", ram_rd); end
        $display("test_reset_mid_session: writes=%0d cpu_hold=%b busy=%b", log_addr.size(), cpu_hold, busy);
    endtask

    task automatic test_start_while_busy();
        stream.delete();
        stream = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67, 8'h45, 8'h23, 8'h01,
                   8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_load(1'b0, 1'b1, 2, 3, 0);
        n_cmp++; if (log_addr.size() !== 2) begin n_err++; $display("FAIL busy_start_write_count got=%0d want=2", log_addr.size()); end
        if (log_addr.size() == 2) begin
            n_cmp++; if (log_data[0] !== 32'hDEAD_BEEF || log_data[1] !== 32'h0123_4567) begin n_err++; $display("FAIL busy_start_data got=%h/%h want=deadbeef/01234567", log_data[0], log_data[1]); end
        end
        n_cmp++; if (done_cyc !== 11) begin n_err++; $display("FAIL busy_start_done_cycle got=%0d want=11", done_cyc); end
        n_cmp++; if (err !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL busy_start_after got=%b/%b want=0/0", err, busy); end
        ram_a = 8'h08;
        #1;
        n_cmp++; if (ram_rd !== 32'h0000_0013) begin n_err++; $display("FAIL busy_start_word2_untouched got=%h want=00000013", ram_rd); end
        $display("test_start_while_busy: writes=%0d done_cyc=%0d", log_addr.size(), done_cyc);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_words = 7'd0;
        in_valid = 1'b0;
        in_data = 8'd0;
        ram_init = 1'b0;
        ram_a = 8'd0;
        test_reset();
        test_load_streaming();
        test_load_gapped();
        test_illegal_count();
        test_reset_mid_session();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
